byte_bus_arbiter: RTL and testbench
===================================

BYTE_BUS_ARBITER -- requirements
Module: byte_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the byte bus (legal range 2..8).
REQ-002 The package typedef byte_t and constant WIDTH (8) SHALL be brought in by a header-level import of the shared package, placed between the module name and the port list.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester valid.
REQ-006 req_data  input  NUM_REQ x byte_t  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 req_ready  output  NUM_REQ  per-requester ready; at most one bit high per cycle.
REQ-008 out_valid  output  1  registered output beat valid.
REQ-009 out_data  output  byte_t  registered output beat.
REQ-010 out_ready  input  1  downstream accepts the beat.
REQ-011 grant_id  output  $clog2(NUM_REQ)  index of the current owner, registered.
REQ-012 busy  output  1  high while the FSM is in BUSY.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-014 In IDLE with any req_valid high, the arbiter SHALL select the first valid index found by searching upward from rr_ptr with wrap, load grant_id, and enter BUSY on the next edge.
REQ-015 In IDLE, req_ready SHALL be all zero.
REQ-016 In BUSY, req_ready[grant_id] SHALL equal (!out_valid || out_ready); all other bits SHALL be 0.
REQ-017 An input handshake (req_valid[grant_id] && req_ready[grant_id]) SHALL load out_data from that requester's slice and set out_valid on the same edge.
REQ-018 out_valid SHALL clear on an edge with out_ready high and no new input handshake; it SHALL stay set, with out_data held, while out_ready is low.
REQ-019 After an input handshake, the FSM SHALL return to IDLE and rr_ptr SHALL become (grant_id+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
REQ-020 In BUSY with req_valid[grant_id] low, the FSM SHALL return to IDLE without a transfer, and rr_ptr SHALL be unchanged.
REQ-021 Latency: req_valid asserted in IDLE at cycle 0 -> busy and grant_id at cycle 1 -> out_valid at cycle 2 (with out_ready high).
REQ-022 Without lock, peak throughput SHALL be one beat every 2 cycles.
REQ-023 A requester deasserting valid in IDLE SHALL simply not be considered; there is no latching of requests.

Reset
REQ-024 On rst high, independent of clk, the block SHALL set state=IDLE, rr_ptr=0, grant_id=0, out_valid=0, out_data=0 and busy=0, and req_ready SHALL read 0.
REQ-025 Reset asserted mid-BUSY or with out_valid pending SHALL drop the beat; no transfer SHALL complete in the cycle of deassertion.

Configuration
REQ-026 Macro BYTE_ARB_LOCK_EN SHALL add input req_lock[NUM_REQ].
REQ-027 With BYTE_ARB_LOCK_EN defined, an input handshake with req_lock[grant_id] high SHALL keep the FSM in BUSY with grant_id and rr_ptr unchanged, allowing one beat per cycle.
REQ-028 With BYTE_ARB_LOCK_EN defined, a handshake with req_lock[grant_id] low SHALL release per REQ-019.
REQ-029 Without BYTE_ARB_LOCK_EN, the req_lock port SHALL not exist and every handshake SHALL release.

Structure
REQ-030 The shared package SHALL hold byte_t, WIDTH, MAX_REQ=8, and the state enum arb_state_e {ARB_IDLE, ARB_BUSY}.
REQ-031 One sub-module rr_pick SHALL be instantiated; it is combinational and maps (req vector, rr_ptr) to (any, index).
REQ-032 The FSM and output register SHALL reside in byte_bus_arbiter.

Verification
REQ-033 Single request: req_valid=4'b0100, req_data[2]=8'hA5, out_ready=1 -> grant_id=2 at cycle 1, out_data=8'hA5 with out_valid at cycle 2, rr_ptr=3.
REQ-034 All requesters: req_valid=4'b1111 held -> grant order 0,1,2,3,0; each beat carries that requester's data.
REQ-035 Backpressure: out_ready=0 with out_valid=1 -> req_ready all 0 and out_data stable; out_ready=1 -> beat drains and the next grant proceeds.
REQ-036 Abandon: granted requester drops valid in BUSY -> IDLE next cycle, no out_valid, rr_ptr unchanged.
REQ-037 Reset mid-transfer: rst pulses while out_valid=1 -> out_valid=0 immediately (asynchronously), grant_id=0.
REQ-038 Lock (BYTE_ARB_LOCK_EN): requester 1 with req_lock=1 streams 8'h10..8'h13 over 4 consecutive cycles while requester 3 is valid; requester 3 is granted only after lock drops.

Source files
------------

// File: rtl/byte_bus_arbiter_pkg.sv
// Shared types and constants for the byte bus arbiter.
package byte_bus_arbiter_pkg;

  localparam int WIDTH   = 8;
  localparam int MAX_REQ = 8;

  typedef logic [WIDTH-1:0] byte_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr, with wrap.
module rr_pick
  import byte_bus_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  int s;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    s   = 0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      s = (int'(ptr) + i) % int'(N);
      if (req[s]) begin
        any = 1'b1;
        idx = IW'(s);
      end
    end
  end

endmodule

// File: rtl/byte_bus_arbiter.sv
// Round-robin arbiter sharing one registered byte output among NUM_REQ requesters.
// Optional macro BYTE_ARB_LOCK_EN adds req_lock for back-to-back beats from one owner.
module byte_bus_arbiter
  import byte_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
`ifdef BYTE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output byte_t                      out_data,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic           out_valid_q, out_valid_d;
  byte_t          out_data_q, out_data_d;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           slot_ready;
  logic           xfer;
  logic           lock_hold;

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

`ifdef BYTE_ARB_LOCK_EN
  assign lock_hold = req_lock[grant_q];
`else
  assign lock_hold = 1'b0;
`endif

  // The owner may hand over a beat whenever the output register is empty or draining.
  assign slot_ready = (state_q == ARB_BUSY) && (!out_valid_q || out_ready);
  assign xfer       = slot_ready && req_valid[grant_q];

  always_comb begin
    req_ready = '0;
    if (slot_ready) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data[int'(grant_q)*WIDTH +: WIDTH];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_BUSY;
          grant_d = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (xfer) begin
          if (!lock_hold) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          end
        end else if (!req_valid[grant_q]) begin
          // Owner abandoned its request: release without moving the pointer.
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_byte_bus_arbiter.sv
// Directed self-checking bench for byte_bus_arbiter (NUM_REQ = 4).
module tb_byte_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
`ifdef BYTE_ARB_LOCK_EN
  logic [3:0]  req_lock;
`endif
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [1:0]  grant_id;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_data [4];

  byte_bus_arbiter #(
    .NUM_REQ (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef BYTE_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_data[0] = 8'hC0;
    exp_data[1] = 8'hB1;
    exp_data[2] = 8'hA5;
    exp_data[3] = 8'hD3;

    rst       = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'hD3_A5_B1_C0;
    out_ready = 1'b1;
`ifdef BYTE_ARB_LOCK_EN
    req_lock  = 4'b0000;
`endif
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'h00);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_grant",     32'(grant_id),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Single request from requester 2
    req_valid = 4'b0100;
    chk("idle_req_ready", 32'(req_ready), 32'h0);
    tick();
    chk("single_busy",  32'(busy),      32'd1);
    chk("single_grant", 32'(grant_id),  32'd2);
    chk("single_ready", 32'(req_ready), 32'b0100);
    chk("single_ov_c1", 32'(out_valid), 32'd0);
    tick();
    chk("single_ov_c2", 32'(out_valid), 32'd1);
    chk("single_data",  32'(out_data),  32'hA5);
    chk("single_idle",  32'(busy),      32'd0);
    chk("single_ptr",   32'(dut.rr_ptr_q), 32'd3);
    req_valid = 4'b0000;
    tick();
    chk("single_drain", 32'(out_valid), 32'd0);

    // Async reset between edges brings the pointer back to 0
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    chk("ptr_after_rst", 32'(dut.rr_ptr_q), 32'd0);

    // All requesters held: grants 0,1,2,3,0
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_busy",  32'(busy),     32'd1);
      chk("rr_grant", 32'(grant_id), 32'(k % 4));
      tick();
      chk("rr_ov",    32'(out_valid), 32'd1);
      chk("rr_data",  32'(out_data),  32'(exp_data[k % 4]));
    end
    req_valid = 4'b0000;
    tick();
    chk("rr_drain", 32'(out_valid), 32'd0);
    chk("rr_ptr",   32'(dut.rr_ptr_q), 32'd1);

    // Backpressure: pointer at 1, requester 0 found by wrap
    out_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    chk("bp_grant", 32'(grant_id),  32'd0);
    chk("bp_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("bp_ov",    32'(out_valid), 32'd1);
    chk("bp_data",  32'(out_data),  32'hC0);
    tick();
    chk("bp_busy2",   32'(busy),      32'd1);
    chk("bp_stall_r", 32'(req_ready), 32'h0);
    req_data[7:0] = 8'h5E;
    tick();
    chk("bp_hold_ov", 32'(out_valid), 32'd1);
    chk("bp_hold_d",  32'(out_data),  32'hC0);
    chk("bp_hold_r",  32'(req_ready), 32'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_r", 32'(req_ready), 32'b0001);
    tick();
    chk("bp_next_ov", 32'(out_valid), 32'd1);
    chk("bp_next_d",  32'(out_data),  32'h5E);
    chk("bp_next_idle", 32'(busy),    32'd0);
    req_valid = 4'b0000;
    tick();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Abandon: requester 1 granted then drops valid
    req_valid = 4'b0010;
    tick();
    chk("ab_grant", 32'(grant_id), 32'd1);
    req_valid = 4'b0000;
    chk("ab_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("ab_idle", 32'(busy),      32'd0);
    chk("ab_ov",   32'(out_valid), 32'd0);
    chk("ab_ptr",  32'(dut.rr_ptr_q), 32'd1);

    // Reset with a beat pending
    out_ready = 1'b0;
    req_valid = 4'b1000;
    tick();
    chk("rm_grant", 32'(grant_id), 32'd3);
    tick();
    chk("rm_ov",   32'(out_valid), 32'd1);
    chk("rm_data", 32'(out_data),  32'hD3);
    req_valid = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk("rm_async_ov",    32'(out_valid), 32'd0);
    chk("rm_async_grant", 32'(grant_id),  32'd0);
    chk("rm_async_busy",  32'(busy),      32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rm_no_xfer", 32'(out_valid), 32'd0);

`ifdef BYTE_ARB_LOCK_EN
    // Locked stream from requester 1 while requester 3 waits
    req_lock  = 4'b0010;
    req_valid = 4'b1010;
    tick();
    chk("lk_grant", 32'(grant_id), 32'd1);
    for (int k = 0; k < 4; k++) begin
      req_data[15:8] = 8'h10 + 8'(k);
      if (k == 3) req_lock = 4'b0000;
      tick();
      chk("lk_ov",    32'(out_valid), 32'd1);
      chk("lk_data",  32'(out_data),  32'h10 + 32'(k));
      chk("lk_busy",  32'(busy),      (k == 3) ? 32'd0 : 32'd1);
      chk("lk_owner", 32'(grant_id),  32'd1);
    end
    req_valid = 4'b1000;
    tick();
    chk("lk_next_grant", 32'(grant_id), 32'd3);
    chk("lk_next_busy",  32'(busy),     32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
